axi_riscv_resv_table: RTL and testbench

AXI_RISCV_RESV_TABLE -- requirements
Module: axi_riscv_resv_table

---
 rtl/axi_riscv_resv_table.sv | 186 ++++++++++++++++++
 tb/tb_axi_riscv_resv_table.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_riscv_resv_table.sv
// Reservation table for RISC-V LR/SC over AXI.
// Tracks up to NUM_SLOTS reservations, each owned by one ID and covering one
// address granule. Snooped plain writes break matching reservations. An SC
// result comes back one cycle after the SC is accepted.
module axi_riscv_resv_table #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned ID_WIDTH    = 8,
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned GRANULE_LSB = 3,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BEGIN = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_END   = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 lr_valid_i,
    output logic                                 lr_ready_o,
    input  logic [ADDR_WIDTH-1:0]                lr_addr_i,
    input  logic [ID_WIDTH-1:0]                  lr_id_i,
    input  logic                                 sc_valid_i,
    output logic                                 sc_ready_o,
    input  logic [ADDR_WIDTH-1:0]                sc_addr_i,
    input  logic [ID_WIDTH-1:0]                  sc_id_i,
    output logic                                 sc_resp_valid_o,
    input  logic                                 sc_resp_ready_i,
    output logic                                 sc_resp_ok_o,
    input  logic                                 wr_valid_i,
    input  logic [ADDR_WIDTH-1:0]                wr_addr_i,
    output logic [$clog2(NUM_SLOTS+1)-1:0]       resv_count_o
);

    localparam int unsigned TW = ADDR_WIDTH - GRANULE_LSB;
    localparam int unsigned PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CW = $clog2(NUM_SLOTS+1);

    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [ID_WIDTH-1:0]  id_q  [NUM_SLOTS];
    logic [ID_WIDTH-1:0]  id_d  [NUM_SLOTS];
    logic [TW-1:0]        tag_q [NUM_SLOTS];
    logic [TW-1:0]        tag_d [NUM_SLOTS];
    logic [PW-1:0]        rr_q, rr_d;
    logic                 respValid_q, respValid_d;
    logic                 respOk_q, respOk_d;

    logic          scAccept;
    logic          lrAccept;
    logic [TW-1:0] lrTag, scTag, wrTag;
    logic          lrInRange, scInRange;
    logic          scOk;
    logic          lrHit, freeFound;
    logic [PW-1:0] lrHitIdx, freeIdx, target;

    // Range check via borrow bits, so a zero lower bound does not turn into a
    // constant comparison.
    function automatic logic inRange(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] lo;
        logic [ADDR_WIDTH:0] hi;
        lo = {1'b0, addr} - {1'b0, ADDR_BEGIN};
        hi = {1'b0, ADDR_END} - {1'b0, addr};
        return !lo[ADDR_WIDTH] && !hi[ADDR_WIDTH];
    endfunction

    assign lrTag     = lr_addr_i[ADDR_WIDTH-1:GRANULE_LSB];
    assign scTag     = sc_addr_i[ADDR_WIDTH-1:GRANULE_LSB];
    assign wrTag     = wr_addr_i[ADDR_WIDTH-1:GRANULE_LSB];
    assign lrInRange = inRange(lr_addr_i);
    assign scInRange = inRange(sc_addr_i);

    // SC wins arbitration; a new SC is taken only when the result register is
    // free or being drained this cycle.
    assign sc_ready_o      = !respValid_q || sc_resp_ready_i;
    assign lr_ready_o      = !(sc_valid_i && sc_ready_o);
    assign scAccept        = sc_valid_i && sc_ready_o;
    assign lrAccept        = lr_valid_i && lr_ready_o;
    assign sc_resp_valid_o = respValid_q;
    assign sc_resp_ok_o    = respOk_q;

    // Next-state: snoop first, then the accepted LR or SC acts on the
    // post-snoop table, then the result register.
    always_comb begin
        valid_d     = valid_q;
        id_d        = id_q;
        tag_d       = tag_q;
        rr_d        = rr_q;
        respValid_d = respValid_q;
        respOk_d    = respOk_q;
        scOk        = 1'b0;
        lrHit       = 1'b0;
        lrHitIdx    = '0;
        freeFound   = 1'b0;
        freeIdx     = '0;
        target      = '0;

        if (wr_valid_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (valid_d[i] && tag_q[i] == wrTag) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (scAccept) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (valid_d[i] && id_q[i] == sc_id_i && tag_q[i] == scTag && scInRange) begin
                    scOk = 1'b1;
                end
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (valid_d[i] && id_q[i] == sc_id_i) begin
                    valid_d[i] = 1'b0;
                end
                if (scOk && valid_d[i] && tag_q[i] == scTag) begin
                    valid_d[i] = 1'b0;
                end
            end
        end else if (lrAccept) begin
            if (lrInRange) begin
                for (int i = NUM_SLOTS-1; i >= 0; i--) begin
                    if (valid_d[i] && id_q[i] == lr_id_i) begin
                        lrHit    = 1'b1;
                        lrHitIdx = PW'(i);
                    end
                    if (!valid_d[i]) begin
                        freeFound = 1'b1;
                        freeIdx   = PW'(i);
                    end
                end
                if (lrHit) begin
                    target = lrHitIdx;
                end else if (freeFound) begin
                    target = freeIdx;
                end else begin
                    target = rr_q;
                    if (rr_q == PW'(NUM_SLOTS-1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = rr_q + PW'(1);
                    end
                end
                valid_d[target] = 1'b1;
                id_d[target]    = lr_id_i;
                tag_d[target]   = lrTag;
            end else begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (valid_d[i] && id_q[i] == lr_id_i) begin
                        valid_d[i] = 1'b0;
                    end
                end
            end
        end

        if (scAccept) begin
            respValid_d = 1'b1;
            respOk_d    = scOk;
        end else if (sc_resp_ready_i) begin
            respValid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset also drops a pending result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            id_q        <= '{default: '0};
            tag_q       <= '{default: '0};
            rr_q        <= '0;
            respValid_q <= 1'b0;
            respOk_q    <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            id_q        <= id_d;
            tag_q       <= tag_d;
            rr_q        <= rr_d;
            respValid_q <= respValid_d;
            respOk_q    <= respOk_d;
        end
    end

    // Population count of the registered valid bits.
    always_comb begin
        resv_count_o = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            resv_count_o = resv_count_o + CW'(valid_q[i]);
        end
    end

endmodule

// File: tb/tb_axi_riscv_resv_table.sv
// Directed self-checking bench for the LR/SC reservation table.
module tb_axi_riscv_resv_table;

    logic        clk;
    logic        rst;
    logic        lrValid;
    logic        lrReady;
    logic [63:0] lrAddr;
    logic [7:0]  lrId;
    logic        scValid;
    logic        scReady;
    logic [63:0] scAddr;
    logic [7:0]  scId;
    logic        respValid;
    logic        respReady;
    logic        respOk;
    logic        wrValid;
    logic [63:0] wrAddr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    axi_riscv_resv_table #(
        .ADDR_WIDTH (64),
        .ID_WIDTH   (8),
        .NUM_SLOTS  (4),
        .GRANULE_LSB(3),
        .ADDR_BEGIN (64'h1000),
        .ADDR_END   (64'h1FFF)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .lr_valid_i     (lrValid),
        .lr_ready_o     (lrReady),
        .lr_addr_i      (lrAddr),
        .lr_id_i        (lrId),
        .sc_valid_i     (scValid),
        .sc_ready_o     (scReady),
        .sc_addr_i      (scAddr),
        .sc_id_i        (scId),
        .sc_resp_valid_o(respValid),
        .sc_resp_ready_i(respReady),
        .sc_resp_ok_o   (respOk),
        .wr_valid_i     (wrValid),
        .wr_addr_i      (wrAddr),
        .resv_count_o   (count)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doLr(input logic [7:0] id, input logic [63:0] addr);
        lrValid = 1'b1;
        lrId    = id;
        lrAddr  = addr;
        applyStimulus();
        lrValid = 1'b0;
    endtask

    task automatic doSc(input logic [7:0] id, input logic [63:0] addr);
        scValid = 1'b1;
        scId    = id;
        scAddr  = addr;
        applyStimulus();
        scValid = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        rst       = 1'b1;
        lrValid   = 1'b0;
        lrAddr    = '0;
        lrId      = '0;
        scValid   = 1'b0;
        scAddr    = '0;
        scId      = '0;
        respReady = 1'b1;
        wrValid   = 1'b0;
        wrAddr    = '0;

        // Reset, with an LR offered during reset that must be discarded.
        applyStimulus();
        lrValid = 1'b1;
        lrId    = 8'd1;
        lrAddr  = 64'h1000;
        applyStimulus();
        lrValid = 1'b0;
        checkOutput("reset_resp_valid", 64'(respValid), 64'd0);
        checkOutput("reset_resp_ok", 64'(respOk), 64'd0);
        checkOutput("reset_count", 64'(count), 64'd0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("reset_lr_discarded", 64'(count), 64'd0);

        // Basic LR then SC in the same granule.
        doLr(8'd1, 64'h1008);
        checkOutput("basic_count_after_lr", 64'(count), 64'd1);
        doSc(8'd1, 64'h100C);
        checkOutput("basic_resp_valid", 64'(respValid), 64'd1);
        checkOutput("basic_resp_ok", 64'(respOk), 64'd1);
        checkOutput("basic_count_after_sc", 64'(count), 64'd0);
        applyStimulus();
        checkOutput("basic_resp_drained", 64'(respValid), 64'd0);

        // Snoop write breaks the reservation.
        doLr(8'd1, 64'h1008);
        wrValid = 1'b1;
        wrAddr  = 64'h100F;
        applyStimulus();
        wrValid = 1'b0;
        checkOutput("snoop_count", 64'(count), 64'd0);
        doSc(8'd1, 64'h1008);
        checkOutput("snoop_sc_ok", 64'(respOk), 64'd0);

        // LR and snoop to the same granule in one cycle: LR survives.
        lrValid = 1'b1;
        lrId    = 8'd2;
        lrAddr  = 64'h1010;
        wrValid = 1'b1;
        wrAddr  = 64'h1010;
        applyStimulus();
        lrValid = 1'b0;
        wrValid = 1'b0;
        checkOutput("same_cycle_lr_count", 64'(count), 64'd1);
        doSc(8'd2, 64'h1010);
        checkOutput("same_cycle_lr_sc_ok", 64'(respOk), 64'd1);
        checkOutput("same_cycle_lr_sc_count", 64'(count), 64'd0);

        // SC and snoop to the same granule in one cycle: SC fails.
        doLr(8'd3, 64'h1018);
        scValid = 1'b1;
        scId    = 8'd3;
        scAddr  = 64'h1018;
        wrValid = 1'b1;
        wrAddr  = 64'h101C;
        applyStimulus();
        scValid = 1'b0;
        wrValid = 1'b0;
        checkOutput("same_cycle_sc_ok", 64'(respOk), 64'd0);
        checkOutput("same_cycle_sc_count", 64'(count), 64'd0);

        // Same ID re-reserves: tag overwritten, still one slot.
        doLr(8'd1, 64'h1000);
        doLr(8'd1, 64'h1008);
        checkOutput("overwrite_count", 64'(count), 64'd1);
        doSc(8'd1, 64'h1000);
        checkOutput("overwrite_old_sc_ok", 64'(respOk), 64'd0);
        checkOutput("overwrite_count_after_sc", 64'(count), 64'd0);

        // Fill all slots, fifth ID evicts slot 0 (id 1).
        for (int k = 0; k < 5; k++) begin
            doLr(8'(k + 1), 64'h1000 + 64'(8 * k));
        end
        checkOutput("evict_count_full", 64'(count), 64'd4);
        doSc(8'd1, 64'h1000);
        checkOutput("evict_sc_id1_ok", 64'(respOk), 64'd0);
        checkOutput("evict_count_after_id1", 64'(count), 64'd4);
        doSc(8'd2, 64'h1008);
        checkOutput("evict_sc_id2_ok", 64'(respOk), 64'd1);
        checkOutput("evict_count_after_id2", 64'(count), 64'd3);
        applyStimulus();

        // Reset with a pending result and three valid slots.
        respReady = 1'b0;
        doSc(8'd9, 64'h1010);
        checkOutput("pre_reset_resp_valid", 64'(respValid), 64'd1);
        checkOutput("pre_reset_count", 64'(count), 64'd3);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        respReady = 1'b1;
        checkOutput("mid_reset_resp_valid", 64'(respValid), 64'd0);
        checkOutput("mid_reset_count", 64'(count), 64'd0);

        // Out-of-range addresses, and the range bounds.
        doLr(8'd3, 64'h2000);
        checkOutput("oor_lr_count", 64'(count), 64'd0);
        doSc(8'd3, 64'h2000);
        checkOutput("oor_sc_ok", 64'(respOk), 64'd0);
        doLr(8'd5, 64'h0FFF);
        checkOutput("below_range_count", 64'(count), 64'd0);
        doLr(8'd4, 64'h1FFF);
        checkOutput("top_of_range_count", 64'(count), 64'd1);
        doSc(8'd4, 64'h1FF8);
        checkOutput("top_of_range_sc_ok", 64'(respOk), 64'd1);
        doLr(8'd6, 64'h1000);
        doLr(8'd6, 64'h2000);
        checkOutput("oor_lr_removes_own", 64'(count), 64'd0);

        // Back-to-back SCs with ready high, one result per cycle.
        doLr(8'd1, 64'h1000);
        doLr(8'd2, 64'h1008);
        scValid = 1'b1;
        scId    = 8'd1;
        scAddr  = 64'h1000;
        applyStimulus();
        checkOutput("b2b_first_ok", 64'(respOk), 64'd1);
        scId   = 8'd2;
        scAddr = 64'h1008;
        applyStimulus();
        scValid = 1'b0;
        checkOutput("b2b_second_valid", 64'(respValid), 64'd1);
        checkOutput("b2b_second_ok", 64'(respOk), 64'd1);
        applyStimulus();

        // Simultaneous LR and SC: SC wins, LR is held off.
        lrValid = 1'b1;
        lrId    = 8'd7;
        lrAddr  = 64'h1000;
        scValid = 1'b1;
        scId    = 8'd9;
        scAddr  = 64'h1000;
        #1;
        checkOutput("arb_lr_ready", 64'(lrReady), 64'd0);
        applyStimulus();
        lrValid = 1'b0;
        scValid = 1'b0;
        checkOutput("arb_lr_dropped_count", 64'(count), 64'd0);
        applyStimulus();

        // Shared granule: winning SC clears the other owner; stalled result holds.
        doLr(8'd1, 64'h1100);
        doLr(8'd2, 64'h1100);
        checkOutput("shared_count", 64'(count), 64'd2);
        respReady = 1'b0;
        doSc(8'd2, 64'h1100);
        checkOutput("shared_sc2_ok", 64'(respOk), 64'd1);
        checkOutput("shared_count_after_sc2", 64'(count), 64'd0);
        scValid = 1'b1;
        scId    = 8'd1;
        scAddr  = 64'h1100;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("stall_resp_valid", 64'(respValid), 64'd1);
            checkOutput("stall_resp_ok", 64'(respOk), 64'd1);
            checkOutput("stall_sc_ready", 64'(scReady), 64'd0);
        end
        respReady = 1'b1;
        #1;
        checkOutput("release_sc_ready", 64'(scReady), 64'd1);
        applyStimulus();
        scValid = 1'b0;
        checkOutput("shared_sc1_valid", 64'(respValid), 64'd1);
        checkOutput("shared_sc1_ok", 64'(respOk), 64'd0);
        applyStimulus();
        checkOutput("final_resp_drained", 64'(respValid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
